// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// MSB-first parallel-in serial-out shifter with a valid/ready load handshake;
// a word offered during the final bit streams on with no idle gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] parallel_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic         serial_o,
  output logic         valid_o,
  output logic         last_o
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  piso_state_e   r_state;
  piso_state_e   w_state_nxt;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  w_shift_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_busy;
  logic          w_last;
  logic          w_accept;

  assign w_busy   = (r_state == SHIFT);
  assign w_last   = w_busy && (r_cnt == CNT_LAST);
  assign ready_o  = (r_state == IDLE) || w_last;
  assign w_accept = valid_i && ready_o;

  assign serial_o = w_busy && r_shift[N-1];
  assign valid_o  = w_busy;
  assign last_o   = w_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter returns to zero on the final bit so it never passes N-1.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = parallel_i;
      w_cnt_nxt   = '0;
    end else if (w_busy) begin
      w_shift_nxt = {r_shift[N-2:0], 1'b0};
      if (w_last) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: N=8 protocol cases and an N=16
// loopback through a bench-side deserializer.
module tb_piso_serializer;

  logic        clk;
  logic        rst_n;

  logic [7:0]  par8;
  logic        vin8;
  logic        rdy8, ser8, vout8, last8;

  logic [15:0] par16;
  logic        vin16;
  logic        rdy16, ser16, vout16, last16;

  logic [15:0] des;
  logic [15:0] words [200];

  int checks   = 0;
  int failures = 0;

  piso_serializer #(.N(8)) u_dut8 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .parallel_i (par8),
    .valid_i    (vin8),
    .ready_o    (rdy8),
    .serial_o   (ser8),
    .valid_o    (vout8),
    .last_o     (last8)
  );

  piso_serializer #(.N(16)) u_dut16 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .parallel_i (par16),
    .valid_i    (vin16),
    .ready_o    (rdy16),
    .serial_o   (ser16),
    .valid_o    (vout16),
    .last_o     (last16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) begin
    if (vout16) des <= {des[14:0], ser16};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle8(input string tag);
    check({tag, ".ready"},  {31'd0, rdy8},  32'd1);
    check({tag, ".valid"},  {31'd0, vout8}, 32'd0);
    check({tag, ".serial"}, {31'd0, ser8},  32'd0);
    check({tag, ".last"},   {31'd0, last8}, 32'd0);
  endtask

  initial begin
    logic [7:0] a5_bits;
    logic [7:0] c3_bits;
    logic [7:0] x81_bits;
    a5_bits  = 8'b1010_0101;
    c3_bits  = 8'b1100_0011;
    x81_bits = 8'b1000_0001;

    par8  = '0;
    vin8  = 1'b0;
    par16 = '0;
    vin16 = 1'b0;
    des   = '0;
    rst_n = 1'b1;

    // Reset asserted asynchronously, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_idle8("rst_async");
    check("rst_async.ready16", {31'd0, rdy16},  32'd1);
    check("rst_async.valid16", {31'd0, vout16}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset then idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle8($sformatf("idle%0d", i));
    end

    // Single word 8'hA5.
    par8 = 8'hA5;
    vin8 = 1'b1;
    step();
    vin8 = 1'b0;
    par8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5.serial%0d", i), {31'd0, ser8},  {31'd0, a5_bits[7-i]});
      check($sformatf("a5.valid%0d", i),  {31'd0, vout8}, 32'd1);
      check($sformatf("a5.last%0d", i),   {31'd0, last8}, (i == 7) ? 32'd1 : 32'd0);
      check($sformatf("a5.ready%0d", i),  {31'd0, rdy8},  (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    check_idle8("a5.after");

    // Back-to-back 8'hFF then 8'h00 under continuous valid_i.
    par8 = 8'hFF;
    vin8 = 1'b1;
    step();
    par8 = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("b2b.serial%0d", c), {31'd0, ser8},  (c <= 8) ? 32'd1 : 32'd0);
      check($sformatf("b2b.valid%0d", c),  {31'd0, vout8}, 32'd1);
      check($sformatf("b2b.last%0d", c),   {31'd0, last8}, (c == 8 || c == 16) ? 32'd1 : 32'd0);
      check($sformatf("b2b.ready%0d", c),  {31'd0, rdy8},  (c == 8 || c == 16) ? 32'd1 : 32'd0);
      if (c == 16) vin8 = 1'b0;
      step();
    end
    check_idle8("b2b.after");

    // Busy ignore: 8'h3C offered during bit 3 of an 8'hC3 frame.
    par8 = 8'hC3;
    vin8 = 1'b1;
    step();
    vin8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("busy.serial%0d", c), {31'd0, ser8},  {31'd0, c3_bits[8-c]});
      check($sformatf("busy.valid%0d", c),  {31'd0, vout8}, 32'd1);
      check($sformatf("busy.last%0d", c),   {31'd0, last8}, (c == 8) ? 32'd1 : 32'd0);
      if (c == 3) begin
        par8 = 8'h3C;
        vin8 = 1'b1;
        step();
        vin8 = 1'b0;
        par8 = 8'h00;
      end else begin
        step();
      end
    end
    for (int i = 0; i < 3; i++) begin
      check_idle8($sformatf("busy.after%0d", i));
      step();
    end

    // Reset mid-frame during bit 4 of 8'h81.
    par8 = 8'h81;
    vin8 = 1'b1;
    step();
    vin8 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("mid.serial%0d", c), {31'd0, ser8},  {31'd0, x81_bits[8-c]});
      check($sformatf("mid.valid%0d", c),  {31'd0, vout8}, 32'd1);
      if (c < 4) step();
    end
    #2 rst_n = 1'b0;
    #1;
    check_idle8("mid.rst");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle8($sformatf("mid.post%0d", i));
    end

    // Loopback N=16: 200 words streamed back-to-back.
    for (int i = 0; i < 200; i++) words[i] = 16'($urandom);
    par16 = words[0];
    vin16 = 1'b1;
    step();
    for (int f = 0; f < 200; f++) begin
      for (int c = 1; c <= 16; c++) begin
        if (c == 1) begin
          if (f > 0) check($sformatf("loop.word%0d", f - 1), {16'd0, des}, {16'd0, words[f-1]});
          par16 = (f < 199) ? words[f+1] : 16'h0000;
        end
        check($sformatf("loop.valid%0d_%0d", f, c), {31'd0, vout16}, 32'd1);
        check($sformatf("loop.last%0d_%0d", f, c),  {31'd0, last16}, (c == 16) ? 32'd1 : 32'd0);
        if (c == 16 && f == 199) vin16 = 1'b0;
        step();
      end
    end
    check("loop.word199", {16'd0, des}, {16'd0, words[199]});
    check("loop.idle_valid", {31'd0, vout16}, 32'd0);
    check("loop.idle_ready", {31'd0, rdy16},  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parameterizable parallel-in serial-out shift register with a valid/ready load handshake. It is the transmit counterpart of the team's serial-in parallel-out register. It accepts an N-bit word, then emits it one bit per clock, MSB first, so a deserializer clocked on the same edge reassembles the word unchanged after N cycles. Back-to-back words stream with no idle gap.

## Interface
- N, default 8, word width in bits; legal range N ≥ 2
- clk_i  input  1  system clock; all state updates on the rising edge
- rst_ni  input  1  asynchronous, active-low reset
- parallel_i  input  N  word to serialize; sampled only on an accepted load
- valid_i  input  1  parallel_i holds a word to send
- ready_o  output  1  block can accept a word this cycle
- serial_o  output  1  current serial bit
- valid_o  output  1  serial_o carries a frame bit this cycle
- last_o  output  1  serial_o carries the final (LSB) bit of the frame

## Operation
- States: IDLE and SHIFT. The register shift_reg is N bits wide, and the bit counter cnt is $clog2(N) bits wide.
- Load accept: a load is accepted on any rising edge where valid_i && ready_o. On accept:
  - shift_reg <= parallel_i
  - cnt <= 0
  - state <= SHIFT
- ready_o is combinational: (state == IDLE) || (state == SHIFT && cnt == N-1). The source may therefore queue the next word during the last bit.
- In SHIFT with no accept:
  - shift_reg <= {shift_reg[N-2:0], 1'b0}
  - cnt <= cnt + 1
- When cnt == N-1 and no new word is accepted, state <= IDLE.
- Outputs:
  - serial_o = shift_reg[N-1] when in SHIFT, otherwise 0.
  - valid_o = (state == SHIFT).
  - last_o = (state == SHIFT && cnt == N-1).
- Simultaneous last bit and accept: the new word loads, state stays SHIFT and cnt restarts at 0. The next cycle carries the new MSB with no gap.
- valid_i while busy (cnt < N-1): ignored. parallel_i is not sampled and the frame is not disturbed.
- Reset mid-frame: the frame is abandoned immediately. No partial word is resumed after reset.
- Arithmetic: cnt never exceeds N-1. Wrap-around is prevented by reload or the transition to IDLE, not by modulo overflow.

## Timing
- Reset values, asserted asynchronously while rst_ni == 0: state = IDLE, shift_reg = 0, cnt = 0, serial_o = 0, valid_o = 0, last_o = 0, ready_o = 1.
- Latency: load accepted at edge E → MSB on serial_o with valid_o = 1 during the cycle after E. The LSB (with last_o = 1) appears N-1 cycles later.
- Throughput: one word per N cycles under continuous valid_i.
- Handshake: the source must hold parallel_i stable only during the accept cycle. ready_o may depend on state only, never on valid_i.
- First reset release: ready_o = 1 in the first cycle after rst_ni rises.

## Structure
- Shared package (piso_pkg):
  - state enum {IDLE, SHIFT}
  - function cnt_width(N) returning $clog2(N)
- Single module with no sub-module. The counter and shifter are short enough to stay inline.
- The deserializer pairing check lives in the testbench, not in RTL.

## Test plan
- Reset then idle: hold rst_ni low, then release with valid_i = 0 → ready_o = 1, valid_o = 0, serial_o = 0 for 10 cycles.
- Single word, N = 8: load 8'hA5 → serial_o sequence 1,0,1,0,0,1,0,1 over 8 cycles with valid_o high; last_o high only on the 8th bit; ready_o returns to 1 and valid_o drops the following cycle.
- Back-to-back: hold valid_i = 1 with 8'hFF then 8'h00 → 16 contiguous valid_o cycles (8 ones, then 8 zeros); last_o high at bits 8 and 16; ready_o high only in cycles 8 and 16.
- Busy ignore: pulse valid_i with 8'h3C during bit 3 of an 8'hC3 frame → output stays 1,1,0,0,0,0,1,1 and 8'h3C is never sent.
- Reset mid-frame: drop rst_ni during bit 4 of 8'h81 → all outputs go to reset values immediately; after release, ready_o = 1 and no bits are emitted until a new load.
- Loopback with deserializer, N = 16: random 200 words streamed back-to-back → sample the deserializer output on each cycle after last_o; it equals the sent word for every frame.
